// File: rtl/vend_credit_ctrl_pkg.sv
// Shared types and default constants for the coin-credit vending controller.
package vend_credit_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_HOLD   = 3'b001,
        ST_VEND   = 3'b010,
        ST_REFUND = 3'b011
    } state_e;

    localparam int unsigned DEF_CREDIT_W   = 9;
    localparam int unsigned DEF_COIN0_VAL  = 50;
    localparam int unsigned DEF_COIN1_VAL  = 100;
    localparam int unsigned DEF_COIN2_VAL  = 500;
    localparam int unsigned DEF_PRICE      = 200;
    localparam int unsigned DEF_MAX_CREDIT = 300;

endpackage

// File: rtl/vend_credit_ctrl_edge_trig.sv
// Registered rising-edge detector: one trig pulse per low-to-high transition of each bit.
module vend_credit_ctrl_edge_trig #(
    parameter int unsigned N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] level,
    output logic [N-1:0] trig
);

    logic [N-1:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            trig   <= '0;
        end else begin
            prev_q <= level;
            trig   <= level & ~prev_q;
        end
    end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Coin-credit vending controller: accumulates coin credit, vends at PRICE, refunds via handshake.
module vend_credit_ctrl
    import vend_credit_ctrl_pkg::*;
#(
    parameter int unsigned CREDIT_W   = DEF_CREDIT_W,
    parameter int unsigned COIN0_VAL  = DEF_COIN0_VAL,
    parameter int unsigned COIN1_VAL  = DEF_COIN1_VAL,
    parameter int unsigned COIN2_VAL  = DEF_COIN2_VAL,
    parameter int unsigned PRICE      = DEF_PRICE,
    parameter int unsigned MAX_CREDIT = DEF_MAX_CREDIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          coin,
    input  logic                vend_btn,
    input  logic                cancel_btn,
    input  logic                change_ack,
    output logic [2:0]          state,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend,
    output logic                deny,
    output logic                reject,
    output logic                change_req,
    output logic [CREDIT_W-1:0] change_amt
);

    localparam logic [CREDIT_W:0]   C0_V    = (CREDIT_W + 1)'(COIN0_VAL);
    localparam logic [CREDIT_W:0]   C1_V    = (CREDIT_W + 1)'(COIN1_VAL);
    localparam logic [CREDIT_W:0]   C2_V    = (CREDIT_W + 1)'(COIN2_VAL);
    localparam logic [CREDIT_W:0]   MAX_V   = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_V = CREDIT_W'(PRICE);

    logic [4:0] trig;
    logic [2:0] coin_trig;
    logic       vend_trig;
    logic       cancel_trig;

    vend_credit_ctrl_edge_trig #(
        .N(5)
    ) u_edge_trig (
        .clk  (clk),
        .rst  (rst),
        .level({cancel_btn, vend_btn, coin}),
        .trig (trig)
    );

    assign coin_trig   = trig[2:0];
    assign vend_trig   = trig[3];
    assign cancel_trig = trig[4];

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] amt_q, amt_d;
    logic                vend_q, vend_d;
    logic                deny_q, deny_d;
    logic                reject_q, reject_d;

    logic [2:0]          coin_first;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   coin_sum;

    // Only the lowest-indexed coin trig is considered; the rest are returned.
    assign coin_first = coin_trig & (~coin_trig + 3'd1);

    always_comb begin
        coin_val = '0;
        if (coin_trig[0]) begin
            coin_val = C0_V;
        end else if (coin_trig[1]) begin
            coin_val = C1_V;
        end else if (coin_trig[2]) begin
            coin_val = C2_V;
        end
    end

    assign coin_sum = {1'b0, credit_q} + coin_val;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        amt_d    = amt_q;
        vend_d   = 1'b0;
        deny_d   = 1'b0;
        reject_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (vend_trig) begin
                    reject_d = |coin_trig;
                    if (credit_q >= PRICE_V) begin
                        credit_d = credit_q - PRICE_V;
                        vend_d   = 1'b1;
                        state_d  = ST_VEND;
                    end else begin
                        deny_d = 1'b1;
                    end
                end else if (cancel_trig && (credit_q != '0)) begin
                    reject_d = |coin_trig;
                    amt_d    = credit_q;
                    state_d  = ST_REFUND;
                end else if (|coin_trig) begin
                    reject_d = |(coin_trig & ~coin_first);
                    if (coin_sum <= MAX_V) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = ST_HOLD;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                // Coins arriving during the vend cycle cannot be credited.
                reject_d = |coin_trig;
                if (credit_q != '0) begin
                    amt_d   = credit_q;
                    state_d = ST_REFUND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REFUND: begin
                reject_d = |coin_trig;
                if (change_ack) begin
                    credit_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            amt_q    <= '0;
            vend_q   <= 1'b0;
            deny_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            amt_q    <= amt_d;
            vend_q   <= vend_d;
            deny_q   <= deny_d;
            reject_q <= reject_d;
        end
    end

    assign state      = state_q;
    assign credit     = credit_q;
    assign vend       = vend_q;
    assign deny       = deny_q;
    assign reject     = reject_q;
    assign change_req = (state_q == ST_REFUND);
    assign change_amt = amt_q;

endmodule
